i2c_byte_transfer: RTL and testbench

Clocked, parametrised I2C master byte engine: transfers one byte per request in either direction, write (8 data bits out, ACK sampled) or read (8 data bits in, ACK/NACK driven), with bounded clock-stretch tolerance. Sits between the transaction sequencer (which issues START/STOP and byte requests) and the open-drain SDA/SCL pads. Replaces the per-call byte task with a free-running FSM and a start/done handshake.

---
 rtl/i2c_master_pkg.sv | 27 ++
 rtl/i2c_bit_phase.sv | 46 ++++
 rtl/i2c_byte_transfer.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_byte_transfer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_pkg.sv
// Shared definitions for the I2C master byte engine: FSM state codes, bit-index
// width, default timing parameters and the SDA drive rule.
package i2c_master_pkg;

    localparam int BIT_IDX_W           = 4;
    localparam int DEF_QUARTER_CYCLES  = 125;
    localparam int DEF_STRETCH_TIMEOUT = 1000;

    localparam logic [BIT_IDX_W-1:0] IDX_MSB = 4'd8;
    localparam logic [BIT_IDX_W-1:0] IDX_ACK = 4'd0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_RISE   = 3'd2;
    localparam logic [2:0] S_HIGH   = 3'd3;
    localparam logic [2:0] S_FALL   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    // 1 = pull SDA low. Data bits come from the MSB of the outgoing shifter;
    // on the ACK bit only a reader that wants to ACK drives the line.
    function automatic logic sda_drive(input logic rd, input logic ack_bit,
                                       input logic msb, input logic send_ack);
        if (ack_bit) return rd & send_ack;
        return ~rd & ~msb;
    endfunction

endpackage

// File: rtl/i2c_bit_phase.sv
// Phase timer for the byte engine: counts clk cycles within the current SCL
// phase and counts cycles a slave holds SCL low after release.
module i2c_bit_phase
    import i2c_master_pkg::*;
#(
    parameter int  QUARTER_CYCLES  = DEF_QUARTER_CYCLES,
    parameter int  STRETCH_TIMEOUT = DEF_STRETCH_TIMEOUT,
    localparam int CNT_W           = $clog2(2 * QUARTER_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [CNT_W-1:0] phase_last,
    input  logic             stretch_en,
    input  logic             scl_in,
    output logic             phase_end,
    output logic             stretch_timeout
);

    localparam int               STR_W    = $clog2(STRETCH_TIMEOUT + 1);
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRETCH_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [STR_W-1:0] str_d, str_q;
    logic             stretching;

    assign stretching      = stretch_en && !scl_in;
    assign phase_end       = (cnt_q == phase_last);
    assign stretch_timeout = stretching && (str_q == STR_LAST);

    always_comb begin
        cnt_d = restart ? '0 : cnt_q + CNT_W'(1);
        str_d = stretching ? str_q + STR_W'(1) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            str_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            str_q <= str_d;
        end
    end

endmodule

// File: rtl/i2c_byte_transfer.sv
// I2C master byte engine: one byte per start pulse, write or read, with bounded
// clock-stretch tolerance. Define I2C_BYTE_ARB_LOST_EN for arbitration-loss detection.
module i2c_byte_transfer
    import i2c_master_pkg::*;
#(
    parameter int QUARTER_CYCLES  = DEF_QUARTER_CYCLES,
    parameter int STRETCH_TIMEOUT = DEF_STRETCH_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       read_mode,
    input  logic [7:0] tx_byte,
    input  logic       send_ack,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       nack,
    output logic       timeout,
    output logic       arb_lost
);

    localparam int               CNT_W     = $clog2(2 * QUARTER_CYCLES);
    localparam logic [CNT_W-1:0] QTR_LAST  = CNT_W'(QUARTER_CYCLES - 1);
    // The RISE cycle that sees SCL high already counts as the first high cycle.
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(2 * QUARTER_CYCLES - 2);

    logic [2:0]           state_d, state_q;
    logic [BIT_IDX_W-1:0] idx_d, idx_q;
    logic                 rd_d, rd_q;
    logic                 sack_d, sack_q;
    logic [7:0]           shift_d, shift_q;
    logic [7:0]           rx_d, rx_q;
    logic                 nack_d, nack_q;
    logic                 tmo_d, tmo_q;
    logic                 park_d, park_q;

    logic             accept;
    logic             arb_hit;
    logic             restart;
    logic [CNT_W-1:0] phase_last;
    logic             stretch_en;
    logic             phase_end;
    logic             stretch_timeout;
    logic             drive_bit;

    assign accept = (state_q == S_IDLE) && start;

    i2c_bit_phase #(
        .QUARTER_CYCLES (QUARTER_CYCLES),
        .STRETCH_TIMEOUT(STRETCH_TIMEOUT)
    ) u_phase (
        .clk            (clk),
        .reset          (reset),
        .restart        (restart),
        .phase_last     (phase_last),
        .stretch_en     (stretch_en),
        .scl_in         (scl_in),
        .phase_end      (phase_end),
        .stretch_timeout(stretch_timeout)
    );

`ifdef I2C_BYTE_ARB_LOST_EN
    logic arb_d, arb_q;

    // We released SDA for a '1' data bit but another master holds it low.
    assign arb_hit = (state_q == S_HIGH) && !rd_q && (idx_q != IDX_ACK)
                     && shift_q[7] && !sda_in;

    always_comb begin
        arb_d = arb_q;
        if (accept)       arb_d = 1'b0;
        else if (arb_hit) arb_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) arb_q <= 1'b0;
        else       arb_q <= arb_d;
    end

    assign arb_lost = arb_q;
`else
    assign arb_hit  = 1'b0;
    assign arb_lost = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_d       = rd_q;
        sack_d     = sack_q;
        shift_d    = shift_q;
        rx_d       = rx_q;
        nack_d     = nack_q;
        tmo_d      = tmo_q;
        park_d     = park_q;
        restart    = 1'b0;
        phase_last = QTR_LAST;
        stretch_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rd_d    = read_mode;
                    sack_d  = send_ack;
                    shift_d = tx_byte;
                    rx_d    = '0;
                    nack_d  = 1'b0;
                    tmo_d   = 1'b0;
                    idx_d   = IDX_MSB;
                    restart = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    restart = 1'b1;
                    state_d = S_RISE;
                end
            end
            S_RISE: begin
                stretch_en = 1'b1;
                if (scl_in) begin
                    restart = 1'b1;
                    state_d = S_HIGH;
                end else if (stretch_timeout) begin
                    tmo_d   = 1'b1;
                    park_d  = 1'b0;
                    state_d = S_FINISH;
                end
            end
            S_HIGH: begin
                phase_last = HIGH_LAST;
                if (arb_hit) begin
                    park_d  = 1'b0;
                    state_d = S_FINISH;
                end else if (phase_end) begin
                    if (idx_q == IDX_ACK) begin
                        if (!rd_q) nack_d = sda_in;
                    end else if (rd_q) begin
                        rx_d = {rx_q[6:0], sda_in};
                    end
                    restart = 1'b1;
                    state_d = S_FALL;
                end
            end
            S_FALL: begin
                if (phase_end) begin
                    restart = 1'b1;
                    if (idx_q == IDX_ACK) begin
                        park_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q - BIT_IDX_W'(1);
                        shift_d = {shift_q[6:0], 1'b0};
                        state_d = S_SETUP;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rx_q    <= '0;
            nack_q  <= 1'b0;
            tmo_q   <= 1'b0;
            park_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rx_q    <= rx_d;
            nack_q  <= nack_d;
            tmo_q   <= tmo_d;
            park_q  <= park_d;
        end
    end

    // Transfer operands are only consumed after a start has loaded them.
    always_ff @(posedge clk) begin
        rd_q    <= rd_d;
        sack_q  <= sack_d;
        shift_q <= shift_d;
    end

    assign drive_bit = sda_drive(rd_q, idx_q == IDX_ACK, shift_q[7], sack_q);

    // Between bytes SCL stays pulled low unless the last byte ended abnormally.
    always_comb begin
        sda_oe = 1'b0;
        scl_oe = park_q;
        case (state_q)
            S_SETUP, S_FALL: begin
                scl_oe = 1'b1;
                sda_oe = drive_bit;
            end
            S_RISE, S_HIGH: begin
                scl_oe = 1'b0;
                sda_oe = drive_bit;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done    = (state_q == S_FINISH);
    assign rx_byte = rx_q;
    assign nack    = nack_q;
    assign timeout = tmo_q;

endmodule

// File: tb/tb_i2c_byte_transfer.sv
// Bench for i2c_byte_transfer: behavioural open-drain slave with stretch and
// arbitration hooks, expected results queued per byte and compared at done.
module tb_i2c_byte_transfer;

    localparam int Q        = 4;
    localparam int T        = 1000;
    localparam int BYTE_CYC = 36 * Q + 1;

    logic       clk = 1'b0;
    logic       reset, start, read_mode, send_ack;
    logic [7:0] tx_byte, rx_byte;
    logic       sda_in, scl_in, sda_oe, scl_oe;
    logic       busy, done, nack, timeout, arb_lost;

    always #5 clk = ~clk;

    i2c_byte_transfer #(.QUARTER_CYCLES(Q), .STRETCH_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .start(start), .read_mode(read_mode),
        .tx_byte(tx_byte), .send_ack(send_ack), .sda_in(sda_in), .scl_in(scl_in),
        .sda_oe(sda_oe), .scl_oe(scl_oe), .busy(busy), .done(done),
        .rx_byte(rx_byte), .nack(nack), .timeout(timeout), .arb_lost(arb_lost)
    );

    // Slave controls
    logic       slv_read, slv_ack, slv_arb, slv_str_on;
    logic [7:0] slv_byte;
    int         slv_arb_bit, slv_str_bit, slv_str_len;

    // Bus monitor state
    int         falls = 0, sctr = 0, cyc = 0;
    logic       prev_scl = 1'b0, prev_sda = 1'b0;
    logic [7:0] obs_pat = '0;
    logic       obs_ack = 1'b0;
    logic       slv_sda_low, slv_scl_hold;
    logic [2:0] bsel, psel;

    assign sda_in = ~sda_oe & ~slv_sda_low;
    assign scl_in = ~scl_oe & ~slv_scl_hold;

    always_comb begin
        bsel        = 3'(7 - falls);
        slv_sda_low = 1'b0;
        if (slv_read) begin
            if (falls < 8) slv_sda_low = ~slv_byte[bsel];
        end else if (falls == 8) begin
            slv_sda_low = slv_ack;
        end
        if (slv_arb && falls == slv_arb_bit) slv_sda_low = 1'b1;
        slv_scl_hold = slv_str_on && (falls == slv_str_bit) && (sctr < slv_str_len);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        sctr <= scl_oe ? 0 : sctr + 1;
        if (!busy) begin
            falls    <= 0;
            prev_scl <= 1'b0;
        end else begin
            if (prev_scl && scl_oe) begin
                psel = 3'(7 - falls);
                if (falls < 8) obs_pat[psel] <= prev_sda;
                else           obs_ack <= prev_sda;
                falls <= falls + 1;
            end
            prev_scl <= scl_in;
            prev_sda <= sda_in;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] rx;
        logic       nack;
        logic       tmo;
        logic       arb;
        logic       scl_fin;
        logic       chk_pat;
        logic [7:0] pat;
        logic       chk_ack;
        logic       ack_line;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk_exp(input logic [7:0] rx, input logic nk, input logic tmo,
                                    input logic arb, input logic scl_fin, input logic chk_pat,
                                    input logic [7:0] pat, input logic chk_ack,
                                    input logic ack_line, input int done_rel);
        exp_t e;
        e.rx = rx; e.nack = nk; e.tmo = tmo; e.arb = arb; e.scl_fin = scl_fin;
        e.chk_pat = chk_pat; e.pat = pat; e.chk_ack = chk_ack; e.ack_line = ack_line;
        e.done_cyc = done_rel;
        return e;
    endfunction

    task automatic issue(input logic rd, input logic [7:0] tx, input logic sack, input exp_t e);
        @(negedge clk);
        read_mode = rd;
        tx_byte   = tx;
        send_ack  = sack;
        start     = 1'b1;
        e.done_cyc = cyc + e.done_cyc;
        sb.push_back(e);
        check_val("busy_before_start", busy, 0);
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_start", busy, 1);
    endtask

    task automatic finish_byte(input string name);
        int   n = 0;
        exp_t e;
        while (done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1 || sb.size() == 0) begin
            check_val($sformatf("%s_done_seen", name), 0, 1);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        check_val($sformatf("%s_done_cycle", name), cyc, e.done_cyc);
        check_val($sformatf("%s_rx_byte", name), rx_byte, e.rx);
        check_val($sformatf("%s_nack", name), nack, e.nack);
        check_val($sformatf("%s_timeout", name), timeout, e.tmo);
        check_val($sformatf("%s_arb_lost", name), arb_lost, e.arb);
        check_val($sformatf("%s_busy_at_done", name), busy, 0);
        check_val($sformatf("%s_sda_oe_at_done", name), sda_oe, 0);
        check_val($sformatf("%s_scl_oe_at_done", name), scl_oe, e.scl_fin);
        if (e.chk_pat) check_val($sformatf("%s_sda_pattern", name), obs_pat, e.pat);
        if (e.chk_ack) check_val($sformatf("%s_ack_line", name), obs_ack, e.ack_line);
        @(negedge clk);
        check_val($sformatf("%s_done_one_cycle", name), done, 0);
        check_val($sformatf("%s_scl_oe_idle", name), scl_oe, e.scl_fin);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; read_mode = 1'b0; tx_byte = '0; send_ack = 1'b0;
        slv_read = 1'b0; slv_ack = 1'b0; slv_arb = 1'b0; slv_str_on = 1'b0;
        slv_byte = '0; slv_arb_bit = 0; slv_str_bit = 0; slv_str_len = 0;
        repeat (3) @(negedge clk);
        check_val("rst_sda_oe", sda_oe, 0);
        check_val("rst_scl_oe", scl_oe, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_rx_byte", rx_byte, 0);
        check_val("rst_nack", nack, 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_arb_lost", arb_lost, 0);
        reset = 1'b0;

        // Write 0xA5, slave ACKs; a start pulse mid-byte must be ignored
        slv_ack = 1'b1;
        issue(1'b0, 8'hA5, 1'b0, mk_exp(8'h00, 0, 0, 0, 1, 1, 8'hA5, 1, 0, BYTE_CYC));
        repeat (20) @(negedge clk);
        start = 1'b1; tx_byte = 8'h00; read_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_byte("wr_a5");

        // Write 0x3C, slave NACKs
        slv_ack = 1'b0;
        issue(1'b0, 8'h3C, 1'b0, mk_exp(8'h00, 1, 0, 0, 1, 1, 8'h3C, 1, 1, BYTE_CYC));
        finish_byte("wr_3c");

        // Read 0x5A, master NACKs
        slv_read = 1'b1; slv_byte = 8'h5A;
        issue(1'b1, 8'h00, 1'b0, mk_exp(8'h5A, 0, 0, 0, 1, 1, 8'h5A, 1, 1, BYTE_CYC));
        finish_byte("rd_5a");

        // Read 0xC3, master ACKs, 500-cycle stretch on bit index 3
        slv_byte = 8'hC3; slv_str_on = 1'b1; slv_str_bit = 5; slv_str_len = 500;
        issue(1'b1, 8'h00, 1'b1, mk_exp(8'hC3, 0, 0, 0, 1, 1, 8'hC3, 1, 0, BYTE_CYC + 500));
        finish_byte("rd_stretch");

        // Stretch beyond the limit on bit index 5
        slv_read = 1'b0; slv_ack = 1'b1; slv_str_bit = 3; slv_str_len = 1200;
        issue(1'b0, 8'h96, 1'b0, mk_exp(8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 13 * Q + 1 + T));
        finish_byte("timeout");
        slv_str_on = 1'b0;

        // Asynchronous reset in the middle of a byte
        issue(1'b0, 8'h00, 1'b0, mk_exp(8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, BYTE_CYC));
        repeat (30) @(negedge clk);
        check_val("pre_rst_busy", busy, 1);
        check_val("pre_rst_sda_oe", sda_oe, 1);
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_sda_oe", sda_oe, 0);
        check_val("mid_rst_scl_oe", scl_oe, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_rx_byte", rx_byte, 0);
        check_val("mid_rst_nack", nack, 0);
        check_val("mid_rst_timeout", timeout, 0);
        check_val("mid_rst_arb_lost", arb_lost, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;

        // Recovery write after reset
        issue(1'b0, 8'h81, 1'b0, mk_exp(8'h00, 0, 0, 0, 1, 1, 8'h81, 1, 0, BYTE_CYC));
        finish_byte("wr_81");

`ifdef I2C_BYTE_ARB_LOST_EN
        // Another master pulls SDA low on bit index 7 while we send 0xFF
        slv_ack = 1'b0; slv_arb = 1'b1; slv_arb_bit = 1;
        issue(1'b0, 8'hFF, 1'b0, mk_exp(8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 5 * Q + 3));
        finish_byte("arb");
        slv_arb = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
